// File: rtl/lz77_window_decoder.sv
// LZ77 decompressor back end: expands (offset, length, literal) tokens through a
// circular history window and streams the rebuilt bytes with valid/ready flow control.
module lz77_window_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 64,
    parameter int ADDR_W     = 6,
    parameter int LEN_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic [ADDR_W-1:0]     tok_offset,
    input  logic [LEN_W-1:0]      tok_length,
    input  logic [DATA_WIDTH-1:0] tok_literal,
    input  logic                  tok_last,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  err_offset
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_LIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   FILL_MAX = WIN_SIZE[ADDR_W:0];

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_wr_ptr;
    logic [ADDR_W-1:0]       r_rd_ptr;
    logic [ADDR_W:0]         r_fill;
    logic [LEN_W-1:0]        r_remaining;
    logic [DATA_WIDTH-1:0]   r_literal;
    logic                    r_last;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dout_valid;
    logic                    r_dout_last;
    logic                    r_err_offset;
    logic [DATA_WIDTH-1:0]   r_win [WIN_SIZE];

    logic                    w_adv;
    logic                    w_off_legal;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_win_we;
    logic [DATA_WIDTH-1:0]   w_win_wdata;

    // Fill level counts bytes written but never exceeds the window depth.
    function automatic logic [ADDR_W:0] fill_inc(input logic [ADDR_W:0] f);
        if (f == FILL_MAX) begin
            return f;
        end else begin
            return f + {{ADDR_W{1'b0}}, 1'b1};
        end
    endfunction

    // Advance condition, offset legality and the window write port.
    always_comb begin
        w_adv       = !r_dout_valid || dout_ready;
        w_rd_data   = r_win[r_rd_ptr];
        w_off_legal = (tok_offset != {ADDR_W{1'b0}}) && ({1'b0, tok_offset} <= r_fill);
        w_win_we    = 1'b0;
        w_win_wdata = r_literal;
        case (r_state)
            S_COPY: begin
                w_win_we    = w_adv && !clr;
                w_win_wdata = w_rd_data;
            end
            S_LIT: begin
                w_win_we    = w_adv && !clr;
                w_win_wdata = r_literal;
            end
            default: begin
                w_win_we    = 1'b0;
                w_win_wdata = r_literal;
            end
        endcase
    end

    // History window storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_win_we) begin
            r_win[r_wr_ptr] <= w_win_wdata;
        end
    end

    // Token FSM, pointers and the registered output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= {ADDR_W{1'b0}};
            r_rd_ptr     <= {ADDR_W{1'b0}};
            r_fill       <= {(ADDR_W+1){1'b0}};
            r_remaining  <= {LEN_W{1'b0}};
            r_literal    <= {DATA_WIDTH{1'b0}};
            r_last       <= 1'b0;
            r_dout       <= {DATA_WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_err_offset <= 1'b0;
        end else if (clr) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= {ADDR_W{1'b0}};
            r_rd_ptr     <= {ADDR_W{1'b0}};
            r_fill       <= {(ADDR_W+1){1'b0}};
            r_remaining  <= {LEN_W{1'b0}};
            r_literal    <= {DATA_WIDTH{1'b0}};
            r_last       <= 1'b0;
            r_dout       <= {DATA_WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_err_offset <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_adv) begin
                        r_dout_valid <= 1'b0;
                    end
                    // Token acceptance does not wait on the output stage: it emits nothing.
                    if (tok_valid) begin
                        r_literal <= tok_literal;
                        r_last    <= tok_last;
                        if ((tok_length != {LEN_W{1'b0}}) && w_off_legal) begin
                            r_rd_ptr    <= r_wr_ptr - tok_offset;
                            r_remaining <= tok_length;
                            r_state     <= S_COPY;
                        end else begin
                            if (tok_length != {LEN_W{1'b0}}) begin
                                r_err_offset <= 1'b1;
                            end
                            r_state <= S_LIT;
                        end
                    end
                end
                S_COPY: begin
                    if (w_adv) begin
                        r_dout       <= w_rd_data;
                        r_dout_valid <= 1'b1;
                        r_dout_last  <= 1'b0;
                        r_rd_ptr     <= r_rd_ptr + PTR_ONE;
                        r_wr_ptr     <= r_wr_ptr + PTR_ONE;
                        r_fill       <= fill_inc(r_fill);
                        r_remaining  <= r_remaining - LEN_ONE;
                        if (r_remaining == LEN_ONE) begin
                            r_state <= S_LIT;
                        end
                    end
                end
                S_LIT: begin
                    if (w_adv) begin
                        r_dout       <= r_literal;
                        r_dout_valid <= 1'b1;
                        r_dout_last  <= r_last;
                        r_wr_ptr     <= r_wr_ptr + PTR_ONE;
                        r_fill       <= fill_inc(r_fill);
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tok_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign err_offset = r_err_offset;

endmodule

// File: tb/tb_lz77_window_decoder.sv
// Directed, table-driven bench for lz77_window_decoder: each record is one token
// with its hand-computed output bytes, plus hand sequences for wrap and reset.
module tb_lz77_window_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       tok_valid;
    logic       tok_ready;
    logic [5:0] tok_offset;
    logic [5:0] tok_length;
    logic [7:0] tok_literal;
    logic       tok_last;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic       busy;
    logic       err_offset;

    int errors = 0;
    int checks = 0;

    lz77_window_decoder #(
        .DATA_WIDTH(8), .WIN_SIZE(64), .ADDR_W(6), .LEN_W(6)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_offset(tok_offset), .tok_length(tok_length),
        .tok_literal(tok_literal), .tok_last(tok_last),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .err_offset(err_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr_b;
        logic [5:0]  off;
        logic [5:0]  len;
        logic [7:0]  lit;
        logic        last;
        int          n;
        logic [63:0] bytes;
        logic        err;
        int          stall_at;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_valid", dout_valid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_err", err_offset, 1'b0);
        chk("clr_dout", dout, 8'h00);
    endtask

    task automatic send(input vec_t v);
        int c = 0;
        while (!tok_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!tok_ready) chk("tok_ready_wait", tok_ready, 1'b1);
        tok_valid   = 1'b1;
        tok_offset  = v.off;
        tok_length  = v.len;
        tok_literal = v.lit;
        tok_last    = v.last;
        @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask

    task automatic collect(input vec_t v);
        int got = 0;
        int cyc = 0;
        int stalls = 0;
        while (got < v.n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_after_accept", busy, 1'b1);
                chk("tok_ready_low", tok_ready, 1'b0);
            end
            if (got == v.stall_at && stalls < 3) begin
                dout_ready = 1'b0;
                stalls++;
                chk("bp_valid", dout_valid, 1'b1);
                chk("bp_data", dout, v.bytes[8*got +: 8]);
            end else begin
                dout_ready = 1'b1;
                if (dout_valid) begin
                    chk("byte", dout, v.bytes[8*got +: 8]);
                    chk("last", dout_last, (got == v.n - 1) ? v.last : 1'b0);
                    got++;
                end
            end
        end
        dout_ready = 1'b1;
        chk("byte_count", got, v.n);
    endtask

    task automatic apply(input vec_t v);
        if (v.clr_b) do_clr();
        send(v);
        collect(v);
        chk("err_offset", err_offset, v.err);
    endtask

    initial begin
        vec_t v;
        //          clr   off   len   lit    last  n  bytes                                        err   stall
        tbl[0]  = '{1'b1, 6'd0, 6'd0, 8'h41, 1'b0, 1, 64'h41,                                      1'b0, -1};
        tbl[1]  = '{1'b0, 6'd0, 6'd0, 8'h42, 1'b0, 1, 64'h42,                                      1'b0, -1};
        tbl[2]  = '{1'b0, 6'd0, 6'd0, 8'h43, 1'b0, 1, 64'h43,                                      1'b0, -1};
        tbl[3]  = '{1'b0, 6'd3, 6'd3, 8'h44, 1'b1, 4, 64'h44_43_42_41,                             1'b0, -1};
        tbl[4]  = '{1'b1, 6'd0, 6'd0, 8'h58, 1'b0, 1, 64'h58,                                      1'b0, -1};
        tbl[5]  = '{1'b0, 6'd1, 6'd5, 8'h59, 1'b0, 6, 64'h59_58_58_58_58_58,                       1'b0, -1};
        tbl[6]  = '{1'b1, 6'd0, 6'd0, 8'h50, 1'b0, 1, 64'h50,                                      1'b0, -1};
        tbl[7]  = '{1'b0, 6'd0, 6'd0, 8'h51, 1'b0, 1, 64'h51,                                      1'b0, -1};
        tbl[8]  = '{1'b0, 6'd5, 6'd2, 8'h5A, 1'b0, 1, 64'h5A,                                      1'b1, -1};
        tbl[9]  = '{1'b0, 6'd2, 6'd2, 8'h21, 1'b1, 3, 64'h21_5A_51,                                1'b1, -1};
        tbl[10] = '{1'b1, 6'd0, 6'd0, 8'h6B, 1'b0, 1, 64'h6B,                                      1'b0, -1};
        tbl[11] = '{1'b0, 6'd0, 6'd1, 8'h6D, 1'b0, 1, 64'h6D,                                      1'b1, -1};
        tbl[12] = '{1'b1, 6'd0, 6'd0, 8'h01, 1'b0, 1, 64'h01,                                      1'b0, -1};
        tbl[13] = '{1'b0, 6'd0, 6'd0, 8'h02, 1'b0, 1, 64'h02,                                      1'b0, -1};
        tbl[14] = '{1'b0, 6'd0, 6'd0, 8'h03, 1'b0, 1, 64'h03,                                      1'b0, -1};
        tbl[15] = '{1'b0, 6'd0, 6'd0, 8'h04, 1'b0, 1, 64'h04,                                      1'b0, -1};
        tbl[16] = '{1'b0, 6'd4, 6'd4, 8'h55, 1'b1, 5, 64'h55_04_03_02_01,                          1'b0, 2};

        rst = 1'b0; clr = 1'b0; tok_valid = 1'b0; tok_offset = 6'd0;
        tok_length = 6'd0; tok_literal = 8'h00; tok_last = 1'b0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_offset, 1'b0);
        chk("rst_tok_ready", tok_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // Wrap: 70 literals then a match reaching back almost a full window.
        do_clr();
        for (int i = 0; i < 70; i++) begin
            v.clr_b = 1'b0; v.off = 6'd0; v.len = 6'd0; v.lit = i[7:0]; v.last = 1'b0;
            v.n = 1; v.bytes = {56'h0, i[7:0]}; v.err = 1'b0; v.stall_at = -1;
            apply(v);
        end
        v.clr_b = 1'b0; v.off = 6'd63; v.len = 6'd4; v.lit = 8'hFF; v.last = 1'b1;
        v.n = 5; v.bytes = 64'hFF_0A_09_08_07; v.err = 1'b0; v.stall_at = -1;
        apply(v);

        // Asynchronous reset in the middle of a long copy.
        do_clr();
        v.clr_b = 1'b0; v.off = 6'd0; v.len = 6'd0; v.lit = 8'h58; v.last = 1'b0;
        v.n = 1; v.bytes = 64'h58; v.err = 1'b0; v.stall_at = -1;
        apply(v);
        v.off = 6'd1; v.len = 6'd20; v.lit = 8'h59;
        send(v);
        @(negedge clk);
        @(negedge clk);
        chk("midcopy_busy", busy, 1'b1);
        chk("midcopy_valid", dout_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_valid", dout_valid, 1'b0);
        chk("arst_last", dout_last, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_tok_ready", tok_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Fill restarts at zero, so offset 1 is now illegal.
        v.off = 6'd1; v.len = 6'd1; v.lit = 8'h71; v.last = 1'b1;
        v.n = 1; v.bytes = 64'h71; v.err = 1'b1; v.stall_at = -1;
        apply(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
